fifo_stream_rd: RTL and testbench

- Read-side consumer of the async FIFO, in the rd_clk domain.
- Drains the FIFO through its registered-read port (rd_en / rd_data, data valid one cycle after rd_en).
- Presents the data as a valid/ready stream with packet framing (m_last every PKT_LEN beats).
- Holds a 3-entry prefetch buffer, so it sustains one beat per cycle with no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_prefetch_buf.sv | 52 +++++
 rtl/fifo_stream_rd.sv | 76 +++++++
 tb/tb_fifo_stream_rd.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream path.
package fifo_pkg;

    localparam int PREFETCH_D = 3;

    typedef logic [1:0] occ_t;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Three-entry circular register buffer feeding the output stream.
module fifo_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              clr,
    output logic [DATA_W-1:0] head_data,
    output occ_t              occ
);

    localparam occ_t LAST_IDX = occ_t'(PREFETCH_D - 1);

    logic [DATA_W-1:0] mem_q [PREFETCH_D];
    occ_t              head_q, tail_q, occ_q;
    logic              do_pop;

    assign do_pop    = pop && (occ_q != '0);
    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PREFETCH_D; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else if (clr) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_data;
                tail_q <= (tail_q == LAST_IDX) ? '0 : tail_q + 2'd1;
            end
            if (do_pop)
                head_q <= (head_q == LAST_IDX) ? '0 : head_q + 2'd1;
            unique case ({push, do_pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_rd.sv
// Drains the async FIFO read port into a framed valid/ready stream.
module fifo_stream_rd
    import fifo_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PKT_LEN = 8
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        buf_level
);

    localparam int          CW   = cnt_w(PKT_LEN);
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

    logic          infl_q;
    logic [CW-1:0] beat_q, beat_d;
    occ_t          occ;
    logic [2:0]    pend;
    logic          hs, push;

    // Issue only from registered state so m_ready never reaches rd_en.
    assign pend       = {1'b0, occ} + {2'b0, infl_q};
    assign fifo_rd_en = rst_n && !fifo_empty && !clr
                        && (pend < 3'(PREFETCH_D));
    assign push       = infl_q && !clr;
    assign m_valid    = (occ != '0);
    assign hs         = m_valid && m_ready;
    assign m_last     = m_valid && (beat_q == LAST);
    assign buf_level  = occ;

    always_comb begin
        beat_d = beat_q;
        if (clr)
            beat_d = '0;
        else if (hs)
            beat_d = (beat_q == LAST) ? '0 : beat_q + CW'(1);
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= 1'b0;
            beat_q <= '0;
        end else begin
            infl_q <= fifo_rd_en;
            beat_q <= beat_d;
        end
    end

    fifo_prefetch_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (rd_clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (hs),
        .clr       (clr),
        .head_data (m_data),
        .occ       (occ)
    );

    always @(posedge rd_clk) begin
        if (rst_n) begin
            assert (pend <= 3'(PREFETCH_D));
            assert (!(push && !hs && occ == 2'd3));
        end
    end

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Directed bench for fifo_stream_rd with a behavioural FIFO source.
module tb_fifo_stream_rd;

    logic        rd_clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = '0;
    logic        clr;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [1:0]  buf_level;

    logic [15:0] mem [0:255];
    int          wp = 0;
    int          rp = 0;
    logic        force_empty = 1'b0;

    logic [15:0] got_d [0:63];
    logic        got_l [0:63];
    int          got_c [0:63];
    int          ng = 0;
    int          cyc = 0;
    int          bad_rd = 0;

    int checks = 0;
    int errors = 0;

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = force_empty || (wp == rp);

    fifo_stream_rd #(.DATA_W(16), .PKT_LEN(8)) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .clr          (clr),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .buf_level    (buf_level)
    );

    always @(posedge rd_clk) begin
        if (fifo_rd_en && wp != rp) begin
            fifo_rd_data <= mem[rp[7:0]];
            rp <= rp + 1;
        end
    end

    always @(negedge rd_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
        if (m_valid && m_ready && ng < 64) begin
            got_d[ng] = m_data;
            got_l[ng] = m_last;
            got_c[ng] = cyc;
            ng = ng + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d);
        mem[wp[7:0]] = d;
        wp = wp + 1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    int t;
    int base;

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        m_ready = 1'b0;
        #3;
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_level", 32'(buf_level), 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // single word latency
        m_ready = 1'b1;
        ng = 0;
        push(16'h1234);
        #1;
        chk("sw_rd_en_n", 32'(fifo_rd_en), 1);
        chk("sw_valid_n", 32'(m_valid), 0);
        step(1);
        chk("sw_rd_en_n1", 32'(fifo_rd_en), 0);
        chk("sw_valid_n1", 32'(m_valid), 0);
        step(1);
        chk("sw_valid_n2", 32'(m_valid), 1);
        chk("sw_data", 32'(m_data), 32'h1234);
        chk("sw_last", 32'(m_last), 0);
        step(1);
        chk("sw_valid_n3", 32'(m_valid), 0);
        chk("sw_beats", 32'(ng), 1);

        // throughput
        do_clr();
        ng = 0;
        for (int i = 0; i < 16; i++) push(16'(i));
        step(25);
        chk("tp_beats", 32'(ng), 16);
        for (int i = 0; i < 16; i++) begin
            chk("tp_data", 32'(got_d[i]), 32'(i));
            chk("tp_last", 32'(got_l[i]), 32'(i % 8 == 7));
        end
        chk("tp_span", 32'(got_c[15] - got_c[0]), 15);

        // backpressure
        do_clr();
        ng = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
        step(20);
        chk("bp_level", 32'(buf_level), 3);
        chk("bp_rd_en", 32'(fifo_rd_en), 0);
        chk("bp_head", 32'(m_data), 32'h0100);
        chk("bp_valid", 32'(m_valid), 1);
        chk("bp_none", 32'(ng), 0);
        m_ready = 1'b1;
        step(20);
        chk("bp_beats", 32'(ng), 10);
        for (int i = 0; i < 10; i++)
            chk("bp_data", 32'(got_d[i]), 32'h0100 + 32'(i));

        // clr mid-packet
        do_clr();
        ng = 0;
        for (int i = 0; i < 20; i++) push(16'h0200 + 16'(i));
        t = 0;
        while (ng < 3 && t < 40) begin
            step(1);
            t++;
        end
        chk("cl_reach3", 32'(ng), 3);
        clr = 1'b1;
        #1;
        chk("cl_rd_en", 32'(fifo_rd_en), 0);
        step(1);
        clr = 1'b0;
        chk("cl_valid", 32'(m_valid), 0);
        chk("cl_level", 32'(buf_level), 0);
        chk("cl_hs_beat", 32'(got_d[3]), 32'h0203);
        base = ng;
        step(30);
        chk("cl_first", 32'(got_d[base]), 32'h0205);
        for (int i = 0; i < 7; i++)
            chk("cl_nolast", 32'(got_l[base + i]), 0);
        chk("cl_last8", 32'(got_l[base + 7]), 1);
        chk("cl_last8_d", 32'(got_d[base + 7]), 32'h020C);

        // bursty empty
        do_clr();
        ng = 0;
        bad_rd = 0;
        for (int i = 0; i < 24; i++) push(16'h0300 + 16'(i));
        for (int c = 0; c < 60; c++) begin
            force_empty = ((c / 3) % 2) == 1;
            step(1);
        end
        force_empty = 1'b0;
        step(20);
        chk("be_no_rd_empty", 32'(bad_rd), 0);
        chk("be_beats", 32'(ng), 24);
        for (int i = 0; i < 24; i++) begin
            chk("be_data", 32'(got_d[i]), 32'h0300 + 32'(i));
            chk("be_last", 32'(got_l[i]), 32'(i % 8 == 7));
        end

        // async reset with buffered and in-flight data
        do_clr();
        push(16'h0AAA);
        step(5);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h0500 + 16'(i));
        step(3);
        chk("ar_level2", 32'(buf_level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rd_en", 32'(fifo_rd_en), 0);
        chk("ar_valid", 32'(m_valid), 0);
        chk("ar_data", 32'(m_data), 0);
        chk("ar_last", 32'(m_last), 0);
        chk("ar_level", 32'(buf_level), 0);
        step(2);
        rst_n = 1'b1;
        ng = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h0400 + 16'(i));
        step(20);
        chk("ar_beats", 32'(ng), 8);
        chk("ar_first", 32'(got_d[0]), 32'h0400);
        chk("ar_first_last", 32'(got_l[0]), 0);
        chk("ar_last8", 32'(got_l[7]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
